seven_segment_scan_driver: RTL and testbench
============================================

Name: seven_segment_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-bus 7-segment display.
- Successor to the single-digit combinational hex decoder.
- Adds per-digit scanning, a ghosting guard slot, frame-synchronous data commit, leading-zero suppression, per-digit blanking and blink, decimal points, and selectable output polarity.
- Sits between the datapath (which supplies packed hex nibbles) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clocks per digit slot; must be >= 2.
- BLINK_DIV, 64, complete frames per blink half-period; must be >= 1.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_out and dp_out at the pins.
- DIG_ACTIVE_LOW, 0, 1 inverts digit_en at the pins.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle strobe that captures data_in, dp_in, blank_in and blink_en into pending registers
- data_in  input  4*NUM_DIGITS  packed hex nibbles; [3:0] is digit 0 (rightmost)
- dp_in  input  NUM_DIGITS  per-digit decimal point request
- blank_in  input  NUM_DIGITS  per-digit force-blank
- blink_en  input  NUM_DIGITS  per-digit blink enable
- lz_suppress  input  1  leading-zero suppression enable; sampled live, not through pending
- seg_out  output  7  segments; bit0=a, bit1=b, ..., bit6=g
- dp_out  output  1  decimal point
- digit_en  output  NUM_DIGITS  digit select; one-hot or all-off
- frame_tick  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all internal state cleared. This covers digit_idx=0, slot_cnt=0, frame counter, blink phase, and the pending and display registers. Outputs are at inactive levels:
  - seg_out=0 and dp_out=0 when SEG_ACTIVE_LOW=0; 7'h7F and 1 when it is 1.
  - digit_en all 0 when DIG_ACTIVE_LOW=0; all 1 when it is 1.
  - frame_tick=0.
- Scan counter: slot_cnt runs 0..REFRESH_DIV-1. On wrap, digit_idx increments; digit_idx wraps from NUM_DIGITS-1 to 0. One frame is NUM_DIGITS*REFRESH_DIV clocks.
- Output timing: all outputs are registered and reflect the state of the previous cycle (latency 1).
- Guard slot: while slot_cnt==0, digit_en is all-off (anti-ghosting). Slots 1..REFRESH_DIV-1 enable digit_idx one-hot.
- Commit: when state is (digit_idx=0, slot_cnt=0), pending registers copy into display registers. frame_tick is high in the following cycle.
- Load capture: load in any cycle overwrites the pending registers; the last load before a commit wins. A load coinciding with the commit cycle is captured and shown from the next frame. Display content never changes mid-frame (no tearing).
- Decode (hex -> seg_out, active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero suppression: with lz_suppress=1, digit k>0 is suppressed if its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
  - A suppressed digit drives segments 0; its dp still follows dp_in.
- Blink: blink phase toggles after every BLINK_DIV completed frames.
- Blanking: when blank_in[k]=1, or (blink_en[k]=1 and blink phase=1), digit k drives segments=0 and dp=0. digit_en timing is unchanged.
- Polarity: inversion is applied last, to the registered values.
- Reset mid-operation: outputs go inactive immediately (asynchronously). The scan restarts at digit 0, slot 0, with empty display registers.
  - A load captured before reset is lost.
  - After release, the first commit happens in the first cycle; frame_tick goes high in the second cycle.

Test Plan:
Configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.
1. Reset: assert rst_n=0 mid-slot while digit 2 is enabled -> same-cycle seg_out=0, digit_en=0000, dp_out=0. After release -> frame_tick pulses once every 16 clocks.
2. Decode/scan: load data_in=16'h1A3F, lz off -> per frame:
   - digit_en 0001 with seg_out=71, then 0010 with 4F, 0100 with 77, 1000 with 06.
   - Each digit is enabled for 3 clocks, preceded by 1 all-off clock.
3. LZ suppression: data_in=16'h0070, lz_suppress=1 -> digits 3 and 2 show seg 00, digit 1 shows 07, digit 0 shows 3F. data_in=16'h0000 -> only digit 0 shows 3F. Set dp_in=1000 with 16'h0000 -> digit 3 shows seg 00 with dp_out=1.
4. Frame-synchronous load: while showing 16'h2222, pulse load with 16'h5555 during digit 1 -> digits 2 and 3 still show 5B that frame; all digits show 6D from the next frame. Two loads in one frame (16'h7777, then 16'h8888) -> next frame shows 7F only.
5. Blink/blank: blink_en=0001, blank_in=0100, data_in=16'h8888 -> digit 2 always shows 00. Digit 0 shows 7F in frames 0-1, 00 in frames 2-3, 7F in frames 4-5.
6. Polarity: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, digit 8 -> seg_out=00 with digit_en=1110 in the digit 0 slot; guard slot gives digit_en=1111 and seg_out=7F.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with a guard slot, frame-synchronous commit,
// leading-zero suppression, blanking/blink, decimal points and selectable pin polarity.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLINK_DIV      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic                      lz_suppress,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_tick
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int FRM_W  = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_DIV - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [SLOT_W-1:0]         r_slot_cnt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [FRM_W-1:0]          r_frame_cnt;
    logic                      r_blink_phase;
    logic [4*NUM_DIGITS-1:0]   r_pend_data,  r_disp_data;
    logic [NUM_DIGITS-1:0]     r_pend_dp,    r_disp_dp;
    logic [NUM_DIGITS-1:0]     r_pend_blank, r_disp_blank;
    logic [NUM_DIGITS-1:0]     r_pend_blink, r_disp_blink;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_digit_en;
    logic                      r_frame_tick;

    logic                      w_slot_wrap;
    logic                      w_frame_end;
    logic                      w_commit;
    logic                      w_guard;
    logic [NUM_DIGITS-1:0]     w_onehot;
    logic [NUM_DIGITS-1:0]     w_suppress;
    logic [3:0]                w_nibble;
    logic                      w_sel_dp, w_sel_blank, w_sel_blink, w_sel_supp;
    logic                      w_blanked;
    logic [6:0]                w_seg_next;
    logic                      w_dp_next;

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_wrap && (r_digit_idx == IDX_LAST);
    assign w_commit    = (r_slot_cnt == '0) && (r_digit_idx == '0);
    assign w_guard     = (r_slot_cnt == '0);
    assign w_onehot    = NUM_DIGITS'(1) << r_digit_idx;

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_run;
        zero_run    = 1'b1;
        w_suppress  = '0;
        w_nibble    = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_blink = 1'b0;
        w_sel_supp  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (r_disp_data[4*k +: 4] == 4'h0);
            w_suppress[k] = lz_suppress && zero_run;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digit_idx == IDX_W'(k)) begin
                w_nibble    = r_disp_data[4*k +: 4];
                w_sel_dp    = r_disp_dp[k];
                w_sel_blank = r_disp_blank[k];
                w_sel_blink = r_disp_blink[k];
                w_sel_supp  = w_suppress[k];
            end
        end
    end

    assign w_blanked  = w_guard || w_sel_blank || (w_sel_blink && r_blink_phase);
    assign w_seg_next = (w_blanked || w_sel_supp) ? 7'h00 : hex_to_seg(w_nibble);
    assign w_dp_next  = !w_blanked && w_sel_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_slot_wrap) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
            end
            if (w_frame_end) begin
                if (r_frame_cnt == FRM_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + FRM_W'(1);
                end
            end
        end
    end

    // Pending takes any load; display only changes at the frame boundary so nothing tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_blink <= '0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_disp_blink <= '0;
        end else begin
            if (load) begin
                r_pend_data  <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_blink <= blink_en;
            end
            if (w_commit) begin
                r_disp_data  <= r_pend_data;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_disp_blink <= r_pend_blink;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= 7'h00;
            r_dp         <= 1'b0;
            r_digit_en   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_digit_en   <= w_guard ? '0 : w_onehot;
            r_frame_tick <= w_commit;
        end
    end

    assign seg_out    = r_seg ^ {7{SEG_ACTIVE_LOW}};
    assign dp_out     = r_dp ^ SEG_ACTIVE_LOW;
    assign digit_en   = r_digit_en ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench: frames of hand-computed digit outputs are queued as stimulus is issued,
// and a monitor pops one entry per enabled digit cycle from both polarity variants.
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in, blank_in, blink_en;
    logic        lz_suppress;

    logic [6:0]  segA, segB;
    logic        dpA, dpB, tickA, tickB;
    logic [3:0]  enA, enB;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
    } expT;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_en(blink_en), .lz_suppress(lz_suppress),
        .seg_out(segA), .dp_out(dpA), .digit_en(enA), .frame_tick(tickA)
    );

    seven_segment_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dutInv (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_en(blink_en), .lz_suppress(lz_suppress),
        .seg_out(segB), .dp_out(dpB), .digit_en(enB), .frame_tick(tickB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d);
        load    = 1'b1;
        data_in = d;
    endtask

    // Wait for the frame start, queue that frame's 12 enabled cycles, then walk its slots.
    task automatic runFrame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] edp,
                            input int la1, input logic [15:0] ld1,
                            input int la2, input logic [15:0] ld2,
                            input logic lzNext, input int stopAt);
        logic [6:0] s [4];
        bit got;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (tickA) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL frame_timeout: got no frame_tick, expected one within 40 cycles");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 3; r++)
                expQ.push_back('{en: 4'(1 << k), seg: s[k], dp: edp[k]});
        for (int j = 1; j <= stopAt; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (j == la1) applyStimulus(ld1);
            if (j == la2) applyStimulus(ld2);
            if (j == 15) lz_suppress = lzNext;
        end
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (enA != 4'b0000) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output: got en=%b seg=%h, expected no enabled digit", enA, segA);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("scan_out", {enA, segA, dpA}, {e.en, e.seg, e.dp});
                        checkOutput("scan_out_inv", {enB, segB, dpB}, {~e.en, ~e.seg, ~e.dp});
                    end
                end else begin
                    checkOutput("guard_out", {segA, dpA}, 32'h0);
                    checkOutput("guard_inv", {enB, segB, dpB}, {4'hF, 7'h7F, 1'b1});
                end
            end
        end
    end

    // First tick lands in the second cycle after release, then every 16 clocks.
    initial begin
        int sinceRel = 0;
        int lastTick = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sinceRel = 0;
                lastTick = -1;
            end else begin
                sinceRel++;
                if (tickA) begin
                    if (lastTick < 0) checkOutput("first_tick", sinceRel, 2);
                    else              checkOutput("tick_period", sinceRel - lastTick, 16);
                    lastTick = sinceRel;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; data_in = 16'h0; dp_in = 4'h0;
        blank_in = 4'h0; blink_en = 4'h0; lz_suppress = 1'b0;
        #12;
        checkOutput("reset_out", {enA, segA, dpA, tickA}, 32'h0);
        checkOutput("reset_out_inv", {enB, segB, dpB, tickB}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(posedge clk); #2 rst_n = 1'b1;

        runFrame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 2, 16'h1A3F, -1, 16'h0, 1'b0, 15);
        runFrame(7'h71, 7'h4F, 7'h77, 7'h06, 4'b0000, 3, 16'h0070, -1, 16'h0, 1'b1, 15);
        runFrame(7'h3F, 7'h07, 7'h00, 7'h00, 4'b0000, 3, 16'h0000, -1, 16'h0, 1'b1, 15);
        dp_in = 4'b1000;
        runFrame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 3, 16'h0000, -1, 16'h0, 1'b1, 15);
        dp_in = 4'b0000;
        runFrame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b1000, 3, 16'h2222, -1, 16'h0, 1'b0, 15);
        runFrame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, 5, 16'h5555, -1, 16'h0, 1'b0, 15);
        runFrame(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000, 3, 16'h7777, 10, 16'h8888, 1'b0, 15);
        runFrame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 15, 16'h9999, -1, 16'h0, 1'b0, 15);
        runFrame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        blank_in = 4'b0100; blink_en = 4'b0001;
        runFrame(7'h6F, 7'h6F, 7'h6F, 7'h6F, 4'b0000, 2, 16'h8888, -1, 16'h0, 1'b0, 15);
        runFrame(7'h00, 7'h7F, 7'h00, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        runFrame(7'h00, 7'h7F, 7'h00, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        runFrame(7'h7F, 7'h7F, 7'h00, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        runFrame(7'h7F, 7'h7F, 7'h00, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        runFrame(7'h00, 7'h7F, 7'h00, 7'h7F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        blank_in = 4'b0000; blink_en = 4'b0000;
        runFrame(7'h00, 7'h7F, 7'h00, 7'h7F, 4'b0000, 4, 16'hFFFF, -1, 16'h0, 1'b0, 9);

        #2;
        checkOutput("pre_reset_en", enA, 4'b0100);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", {enA, segA, dpA, tickA}, 32'h0);
        checkOutput("async_reset_inv", {enB, segB, dpB, tickB}, {4'hF, 7'h7F, 1'b1, 1'b0});
        expQ.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        runFrame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        runFrame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 15);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("queue_drain", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
